// File: rtl/snax_alu_pkg.sv
// Shared SNAX ALU types: op encoding (also used by snax_alu_pe and the CSR decoder),
// controller FSM states and the default element-count width.
package snax_alu_pkg;

   localparam int LEN_WIDTH = 32;

   typedef enum logic [1:0] {
      ALU_XOR = 2'd0,
      ALU_SUB = 2'd1,
      ALU_MUL = 2'd2,
      ALU_ADD = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } ctrl_state_e;

endpackage

// File: rtl/snax_alu_ctrl_if.sv
// Handshake bundle between the job sequencer (master) and the lock-stepped PE lanes,
// streamer and writer (slave).
interface snax_alu_ctrl_if;

   logic                  a_valid;
   logic                  b_valid;
   logic                  c_valid;
   logic                  c_ready;
   logic                  acc_ready;
   snax_alu_pkg::alu_op_e alu_config;

   modport master (
      input  a_valid, b_valid, c_valid, c_ready,
      output acc_ready, alu_config
   );

   modport slave (
      output a_valid, b_valid, c_valid, c_ready,
      input  acc_ready, alu_config
   );

endinterface

// File: rtl/snax_alu_ctrl_cnt.sv
// Clearable, enable-gated up-counter; with Sat set it sticks at all-ones.
module snax_alu_ctrl_cnt #(
   parameter int Width = 32,
   parameter bit Sat   = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr,
   input  logic             en,
   output logic [Width-1:0] cnt
);

   logic at_max;
   assign at_max = Sat && (&cnt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !at_max) begin
         cnt <= cnt + Width'(1);
      end
   end

endmodule

// File: rtl/snax_alu_ctrl.sv
// SNAX ALU job sequencer: gates PE acc_ready so exactly len pairs are consumed with at most
// one result outstanding per PE. Optional busy/stall counters under SNAX_ALU_CTRL_PERF_EN.
module snax_alu_ctrl
   import snax_alu_pkg::*;
#(
   parameter int LenWidth = LEN_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [1:0]          op_i,
   input  logic [LenWidth-1:0] len_i,
   input  logic                clear_i,
   snax_alu_ctrl_if.master     pe,
   output logic                busy_o,
   output logic                done_o,
   output logic [LenWidth-1:0] in_cnt_o,
   output logic [LenWidth-1:0] out_cnt_o,
   output logic [31:0]         perf_cycles_o,
   output logic [31:0]         perf_stall_o
);

   ctrl_state_e         state_q;
   alu_op_e             op_q;
   logic [LenWidth-1:0] len_q;
   logic [LenWidth-1:0] in_cnt, out_cnt;

   logic run, start_fire, in_room, acc_ready, out_fire, cnt_clr;

   assign run        = (state_q == ST_RUN);
   assign start_fire = (state_q == ST_IDLE) && start_i && !clear_i;
   assign in_room    = (in_cnt < len_q);

   // A new pair may only enter when the PE result slot is empty or draining this cycle.
   assign acc_ready = run && !clear_i && pe.a_valid && pe.b_valid && in_room &&
                      (!pe.c_valid || pe.c_ready);
   assign out_fire  = run && !clear_i && pe.c_valid && pe.c_ready && (out_cnt < in_cnt);
   assign cnt_clr   = clear_i || start_fire;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         op_q    <= ALU_ADD;
         len_q   <= '0;
      end else if (clear_i) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  op_q    <= alu_op_e'(op_i);
                  len_q   <= len_i;
                  state_q <= (len_i == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               // len_q >= 1 whenever RUN is entered, so the subtraction cannot wrap.
               if (out_fire && (out_cnt == len_q - LenWidth'(1))) state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   snax_alu_ctrl_cnt #(.Width(LenWidth), .Sat(1'b0)) u_in_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr   (cnt_clr),
      .en    (acc_ready),
      .cnt   (in_cnt)
   );

   snax_alu_ctrl_cnt #(.Width(LenWidth), .Sat(1'b0)) u_out_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr   (cnt_clr),
      .en    (out_fire),
      .cnt   (out_cnt)
   );

`ifdef SNAX_ALU_CTRL_PERF_EN
   snax_alu_ctrl_cnt #(.Width(32), .Sat(1'b1)) u_perf_cycles (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr   (start_fire),
      .en    (run),
      .cnt   (perf_cycles_o)
   );

   snax_alu_ctrl_cnt #(.Width(32), .Sat(1'b1)) u_perf_stall (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr   (start_fire),
      .en    (run && in_room && !acc_ready),
      .cnt   (perf_stall_o)
   );
`else
   assign perf_cycles_o = '0;
   assign perf_stall_o  = '0;
`endif

   assign pe.acc_ready  = acc_ready;
   assign pe.alu_config = op_q;
   assign busy_o        = run;
   assign done_o        = (state_q == ST_DONE);
   assign in_cnt_o      = in_cnt;
   assign out_cnt_o     = out_cnt;

endmodule
